ifu_fetch: RTL

//  Instruction fetch unit. It sits directly upstream of the instruction decoder.
//  - Holds the PC and fetches from instruction memory over a req/ack handshake.
//  - Presents the fetched word to the decoder and holds it until the datapath retires it.
//  - On retire, computes next PC from decoder outputs (jr, jump, npc_sel) and the ALU zero flag.

---
 rtl/ifu_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit
//
// Holds the program counter and fetches from instruction memory over a simple
// req/ack handshake. The fetched word is presented to the decoder and held
// until the datapath retires it. On retire the next PC is computed from the
// decoder's control outputs (jr, jump, npc_sel) and the ALU zero flag.
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned next PC traps into a sticky ERR state that raises
//               fetch_err and stops fetching until reset.
//   undefined : next PC bits [1:0] are forced to zero; fetch_err is tied 0.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   imem_req/imem_addr  fetch request and address (= pc)
//   imem_ack/imem_rdata fetch completion and instruction word
//   instr/instr_valid   current instruction to the decoder and its valid flag
//   pc/pc_plus4         current instruction address and its link value
//   retire              datapath completed instr; advance the PC
//   jump/jr/npc_sel     decoder control for next-PC selection
//   zero                ALU equality flag for beq
//   rs_data             jr target
//   fetch_err           misaligned-target trap flag
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        jump,
  input  logic        jr,
  input  logic        npc_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic        fetch_err
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [1:0] ST_ERR  = 2'd2;
`endif

  logic [1:0]  state;
  logic [31:0] branch_off;
  logic [31:0] next_raw;
  logic [31:0] next_pc;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC select; priority jr > jump > taken branch > sequential.
  // NOTE: every always_comb output gets a value on every path (here through
  // the final else) so no latch is inferred.
  always_comb begin
    if (jr)
      next_raw = rs_data;
    else if (jump)
      next_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (npc_sel && zero)
      next_raw = pc_plus4 + branch_off;
    else
      next_raw = pc_plus4;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign next_pc    = next_raw;
  assign misaligned = |next_raw[1:0];
`else
  // Without the trap, a misaligned target is silently word-aligned.
  assign next_pc   = next_raw & 32'hFFFF_FFFC;
  assign fetch_err = 1'b0;
`endif

  // Request is masked by rst_n so it stays low for the whole reset interval
  // and rises as soon as reset is released.
  assign imem_req  = rst_n && (state == ST_REQ);
  assign imem_addr = pc;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
            end else begin
              pc    <= next_pc;
              state <= ST_REQ;
            end
`else
            pc    <= next_pc;
            state <= ST_REQ;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_ERR: begin
          // Sticky until reset.
          state <= ST_ERR;
        end
`endif
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule
